cam_stream_gen: RTL and testbench



---
 rtl/cam_stream_gen.sv | 216 +++++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: synthetic OV7670-style camera source. It drives VSYNC, HREF
// and a YCbCr 4:2:2 byte stream (Cb Y Cr Y) with the camera's frame and line
// timing, and fills the frame with one of four test patterns.
module cam_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int SQ_SIZE     = 64,
    parameter int SQ_STEP     = 8
) (
    input  logic       CLOCK_24,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       VSYNC,
    output logic       HREF,
    output logic [7:0] D,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    // Two byte clocks per pixel.
    localparam int LINE_CLKS = 2 * (H_ACTIVE + H_BLANK);
    localparam int HW        = $clog2(LINE_CLKS);  // byte position within a line
    localparam int XW        = HW - 1;             // pixel x
    localparam int CW        = HW + 1;             // square x arithmetic, no overflow
    localparam int VW        = 10;                 // line index within a phase

    localparam logic [HW-1:0] LINE_LAST  = HW'(LINE_CLKS - 1);
    localparam logic [HW-1:0] HREF_CLKS  = HW'(2 * H_ACTIVE);
    localparam logic [VW-1:0] VS_LAST    = VW'(VSYNC_LINES - 1);
    localparam logic [VW-1:0] VB_LAST    = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST    = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VF_LAST    = VW'(V_FRONT - 1);
    localparam logic [XW-1:0] BAR_W      = XW'(H_ACTIVE / 8);
    localparam logic [CW-1:0] SQ_STEP_C  = CW'(SQ_STEP);
    localparam logic [CW-1:0] SQ_SIZE_C  = CW'(SQ_SIZE);
    localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
    localparam logic [VW-1:0] SQ_Y0      = VW'((V_ACTIVE - SQ_SIZE) / 2);
    localparam logic [VW-1:0] SQ_Y1      = VW'((V_ACTIVE + SQ_SIZE) / 2);

    typedef enum logic [2:0] {IDLE, VS, VBACK, ACTIVE, VFRONT} state_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycc_t;

    // Colour of one pixel for the frame's latched pattern and square position.
    function automatic ycc_t pixel_ycc(input logic [1:0]    pat,
                                       input logic [CW-1:0] sq_x,
                                       input logic [XW-1:0] x,
                                       input logic [VW-1:0] y);
        ycc_t          c;
        logic [2:0]    bar;
        logic [CW-1:0] xc;
        c   = '{y: 8'd128, cb: 8'd128, cr: 8'd128};
        bar = 3'(x / BAR_W);
        xc  = CW'(x);
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0: c = '{y: 8'd235, cb: 8'd128, cr: 8'd128};
                    3'd1: c = '{y: 8'd210, cb: 8'd16,  cr: 8'd146};
                    3'd2: c = '{y: 8'd170, cb: 8'd166, cr: 8'd16};
                    3'd3: c = '{y: 8'd145, cb: 8'd54,  cr: 8'd34};
                    3'd4: c = '{y: 8'd106, cb: 8'd202, cr: 8'd222};
                    3'd5: c = '{y: 8'd81,  cb: 8'd90,  cr: 8'd240};
                    3'd6: c = '{y: 8'd41,  cb: 8'd240, cr: 8'd110};
                    3'd7: c = '{y: 8'd16,  cb: 8'd128, cr: 8'd128};
                endcase
            end
            2'd1: begin
                if (xc >= sq_x && xc < sq_x + SQ_SIZE_C && y >= SQ_Y0 && y < SQ_Y1)
                    c = '{y: 8'd144, cb: 8'd53, cr: 8'd34};
                else
                    c = '{y: 8'd16, cb: 8'd128, cr: 8'd128};
            end
            2'd2: c.y = x[7:0];
            default: ;  // flat grey
        endcase
        return c;
    endfunction

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [1:0]    pat_q, pat_d;
    logic [CW-1:0] sq_x_q, sq_x_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    d_q, d_d;
    logic          frame_start_q, frame_start_d;

    logic [VW-1:0] last_line;
    logic [CW-1:0] sq_sum;
    logic [XW-1:0] x;
    logic [XW-1:0] x_sel;
    ycc_t          pix;

    // Next frame position: byte within the line, line within the phase, phase.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        pat_d       = pat_q;
        sq_x_d      = sq_x_q;
        frame_cnt_d = frame_cnt_q;
        sq_sum      = sq_x_q + SQ_STEP_C;

        case (state_q)
            VS:      last_line = VS_LAST;
            VBACK:   last_line = VB_LAST;
            ACTIVE:  last_line = VA_LAST;
            VFRONT:  last_line = VF_LAST;
            default: last_line = '0;
        endcase

        if (state_q == IDLE) begin
            if (en) state_d = VS;
        end else begin
            if (hcnt_q == LINE_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == last_line) begin
                    vcnt_d = '0;
                    case (state_q)
                        VS:     state_d = VBACK;
                        VBACK:  state_d = ACTIVE;
                        ACTIVE: state_d = VFRONT;
                        VFRONT: begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            state_d     = en ? VS : IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    vcnt_d = vcnt_q + VW'(1);
                end
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
        end

        // Pattern and square position are frozen for the whole frame.
        if (state_d == VS && state_q != VS) begin
            pat_d  = pattern_sel;
            sq_x_d = (sq_sum + SQ_SIZE_C > H_ACTIVE_C) ? '0 : sq_sum;
        end
    end

    // Output values for the next position; chroma bytes use the even pixel.
    always_comb begin
        x             = hcnt_d[HW-1:1];
        x_sel         = hcnt_d[0] ? x : {x[XW-1:1], 1'b0};
        pix           = pixel_ycc(pat_q, sq_x_q, x_sel, vcnt_d);
        vsync_d       = (state_d == VS);
        frame_start_d = (state_d == VS) && (state_q != VS);
        href_d        = (state_d == ACTIVE) && (hcnt_d < HREF_CLKS);
        d_d           = 8'h00;
        if (href_d) begin
            case (hcnt_d[1:0])
                2'd0:    d_d = pix.cb;
                2'd2:    d_d = pix.cr;
                default: d_d = pix.y;
            endcase
        end
    end

    // Frame sequencer state, counters and per-frame settings.
    always_ff @(posedge CLOCK_24 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            pat_q       <= '0;
            sq_x_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            pat_q       <= pat_d;
            sq_x_q      <= sq_x_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Registered outputs so HREF and D always change on the same edge.
    always_ff @(posedge CLOCK_24 or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            d_q           <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            d_q           <= d_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign VSYNC       = vsync_q;
    assign HREF        = href_q;
    assign D           = d_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen with a shrunken frame geometry. A frame-time
// reference model predicts every output on every cycle; frame-level timing
// is also measured straight from the outputs.
module tb_cam_stream_gen;

    localparam int H_A   = 288;
    localparam int H_B   = 8;
    localparam int VSL   = 2;
    localparam int VB    = 1;
    localparam int VA    = 8;
    localparam int VF    = 1;
    localparam int SQ    = 4;
    localparam int STEP  = 96;
    localparam int LINE  = 2 * (H_A + H_B);
    localparam int FRAME = (VSL + VB + VA + VF) * LINE;
    localparam int ACT0  = (VSL + VB) * LINE;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] pattern_sel;
    logic       VSYNC;
    logic       HREF;
    logic [7:0] D;
    logic       frame_start;
    logic [7:0] frame_cnt;

    cam_stream_gen #(
        .H_ACTIVE(H_A), .V_ACTIVE(VA), .H_BLANK(H_B), .VSYNC_LINES(VSL),
        .V_BACK(VB), .V_FRONT(VF), .SQ_SIZE(SQ), .SQ_STEP(STEP)
    ) dut (
        .CLOCK_24(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
        .VSYNC(VSYNC), .HREF(HREF), .D(D), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int bar_y  [8] = '{235, 210, 170, 145, 106, 81, 41, 16};
    int bar_cb [8] = '{128, 16, 166, 54, 202, 90, 240, 128};
    int bar_cr [8] = '{128, 146, 16, 34, 222, 240, 110, 128};
    int plan   [8] = '{0, 1, 2, 3, 1, 1, 2, 0};

    // Reference model: whether a frame is running and how far into it we are.
    bit m_run    = 1'b0;
    int m_t      = 0;
    int m_pat    = 0;
    int m_sqx    = 0;
    int m_fcnt   = 0;
    int m_frames = 0;

    // Frame-level measurements taken from the DUT outputs.
    bit   fs_seen    = 1'b0;
    int   fs_last    = 0;
    int   vs_cnt     = 0;
    int   href_cnt   = 0;
    int   href_rises = 0;
    int   first_rise = -1;
    logic href_prev  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic void ycc(input int pat, input int sqx, input int x, input int y,
                                output int yv, output int cbv, output int crv);
        int b;
        yv = 128; cbv = 128; crv = 128;
        case (pat)
            0: begin
                b = x / (H_A / 8);
                yv = bar_y[b]; cbv = bar_cb[b]; crv = bar_cr[b];
            end
            1: begin
                if (x >= sqx && x < sqx + SQ && y >= (VA - SQ) / 2 && y < (VA + SQ) / 2) begin
                    yv = 144; cbv = 53; crv = 34;
                end else begin
                    yv = 16; cbv = 128; crv = 128;
                end
            end
            2: yv = x % 256;
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int pat, input int sqx, input int h, input int y);
        int x, ph, yv, cbv, crv;
        x  = h / 2;
        ph = h % 4;
        if (ph == 0 || ph == 2) begin
            ycc(pat, sqx, x - (x % 2), y, yv, cbv, crv);
            return (ph == 0) ? 8'(cbv) : 8'(crv);
        end
        ycc(pat, sqx, x, y, yv, cbv, crv);
        return 8'(yv);
    endfunction

    function automatic void model_start_frame();
        m_run = 1'b1;
        m_t   = 0;
        m_pat = int'(pattern_sel);
        m_sqx = m_sqx + STEP;
        if (m_sqx + SQ > H_A) m_sqx = 0;
        m_frames++;
    endfunction

    function automatic void model_edge();
        if (!m_run) begin
            if (en) model_start_frame();
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_fcnt = (m_fcnt + 1) % 256;
                if (en) model_start_frame();
                else begin m_run = 1'b0; m_t = 0; end
            end
        end
    endfunction

    task automatic check_cycle();
        int   line, h, ay;
        logic e_vs, e_href, e_fs;
        logic [7:0] e_d;
        e_vs = 1'b0; e_href = 1'b0; e_fs = 1'b0; e_d = 8'h00;
        if (m_run) begin
            line   = m_t / LINE;
            h      = m_t % LINE;
            ay     = line - (VSL + VB);
            e_vs   = (line < VSL);
            e_fs   = (m_t == 0);
            e_href = (ay >= 0) && (ay < VA) && (h < 2 * H_A);
            if (e_href) e_d = exp_byte(m_pat, m_sqx, h, ay);
        end
        check("VSYNC", 32'(VSYNC), 32'(e_vs));
        check("HREF", 32'(HREF), 32'(e_href));
        check("D", 32'(D), 32'(e_d));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));

        if (frame_start === 1'b1) begin
            if (fs_seen) begin
                check("fs_period", 32'(cyc - fs_last), 32'(FRAME));
                check("vsync_clks", 32'(vs_cnt), 32'(VSL * LINE));
                check("href_pulses", 32'(href_rises), 32'(VA));
                check("href_clks", 32'(href_cnt), 32'(VA * 2 * H_A));
                check("first_href", 32'(first_rise), 32'(ACT0));
            end
            fs_seen = 1'b1; fs_last = cyc;
            vs_cnt = 0; href_cnt = 0; href_rises = 0; first_rise = -1;
        end
        if (VSYNC === 1'b1) vs_cnt++;
        if (HREF === 1'b1) begin
            href_cnt++;
            if (href_prev !== 1'b1) begin
                href_rises++;
                if (first_rise < 0) first_rise = cyc - fs_last;
            end
        end
        href_prev = HREF;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    // One clock plus pattern_sel churn: random mid-frame, planned just before VS.
    task automatic tick_stim();
        tick();
        if (m_run && m_t == 5) pattern_sel = 2'($urandom);
        if (m_run && m_t == FRAME - 3) pattern_sel = 2'(plan[m_frames % 8]);
    endtask

    initial begin
        int fc_before;
        rst_n = 1'b0; en = 1'b0; pattern_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_VSYNC", 32'(VSYNC), 32'd0);
        check("reset_HREF", 32'(HREF), 32'd0);
        check("reset_D", 32'(D), 32'd0);
        check("reset_frame_start", 32'(frame_start), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;

        // Disabled: stays idle.
        repeat (4) tick();

        // Six back-to-back frames through all patterns, including the square wrap.
        pattern_sel = 2'(plan[0]);
        en = 1'b1;
        for (int c = 0; c < 6 * FRAME; c++) tick_stim();

        // Drop en in the middle of active line 4; the frame must finish.
        for (int c = 0; c < FRAME && !(m_run && m_t == ACT0 + 4 * LINE + 100); c++) tick_stim();
        en = 1'b0;
        fc_before = m_fcnt;
        for (int c = 0; c < FRAME && m_run; c++) tick_stim();
        check("fcnt_after_drop", 32'(frame_cnt), 32'((fc_before + 1) % 256));
        fs_seen = 1'b0;
        repeat (50) tick();

        // Restart, then pulse reset in the middle of active line 3.
        en = 1'b1;
        pattern_sel = 2'($urandom);
        for (int c = 0; c < FRAME && !(m_run && m_t == ACT0 + 3 * LINE + 37); c++) tick_stim();
        #2 rst_n = 1'b0;
        #1;
        check("async_VSYNC", 32'(VSYNC), 32'd0);
        check("async_HREF", 32'(HREF), 32'd0);
        check("async_D", 32'(D), 32'd0);
        check("async_frame_cnt", 32'(frame_cnt), 32'd0);
        m_run = 1'b0; m_t = 0; m_sqx = 0; m_fcnt = 0;
        fs_seen = 1'b0; href_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("restart_frame_start", 32'(frame_start), 32'd1);
        for (int c = 0; c < FRAME + 20; c++) tick_stim();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
